// File: rtl/zpu_sd_pkg.sv
// Shared constants, FSM state type and slot-to-fileno mapping for zpu_sd_bridge.
package zpu_sd_pkg;

    localparam int unsigned CTRL_W           = 6;
    localparam int unsigned CTRL_LBA_SEL     = 0;
    localparam int unsigned CTRL_BLOCK_RD    = 1;
    localparam int unsigned CTRL_BLOCK_WR    = 2;
    localparam int unsigned CTRL_DRV_LO      = 3;
    localparam int unsigned CTRL_DRV_HI      = 5;

    localparam int unsigned STAT_W           = 8;
    localparam int unsigned STAT_IO_DONE     = 0;
    localparam int unsigned STAT_MOUNTED     = 1;
    localparam int unsigned STAT_FILENO_LO   = 2;
    localparam int unsigned STAT_FILETYPE_LO = 5;
    localparam int unsigned STAT_READONLY    = 7;

    localparam int unsigned SLOT_W           = 2;
    localparam int unsigned FILENO_W         = 3;
    localparam int unsigned FILETYPE_W       = 2;

    localparam logic [SLOT_W-1:0] SLOT_UNMAPPED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Firmware numbers the third hps slot (cart) as file 4.
    function automatic logic [FILENO_W-1:0] slot_to_fileno(input logic [SLOT_W-1:0] slot);
        logic [FILENO_W-1:0] fno;
        case (slot)
            2'd1:    fno = 3'd1;
            2'd2:    fno = 3'd4;
            default: fno = 3'd0;
        endcase
        return fno;
    endfunction

endpackage

// File: rtl/zpu_sd_bridge_if.sv
// hps_io virtual-disk side of the bridge: block request handshake and sector buffer port.
interface zpu_sd_bridge_if #(
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned BUF_AW    = 9
) ();
    logic [31:0]          sd_lba;
    logic [NUM_SLOTS-1:0] sd_rd;
    logic [NUM_SLOTS-1:0] sd_wr;
    logic                 sd_ack;
    logic [BUF_AW-1:0]    sd_buff_addr;
    logic [7:0]           sd_buff_dout;
    logic                 sd_buff_wr;
    logic [7:0]           sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_sector_buf.sv
// True dual-port sector buffer, registered read on both ports; port A hps side, port B ZPU side.
module sd_sector_buf #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 8
) (
    input  logic          clk_sys,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    input  logic          a_we,
    output logic [DW-1:0] a_q,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    input  logic          b_we,
    output logic [DW-1:0] b_q
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Same-address collision: the ZPU write lands last.
    always_ff @(posedge clk_sys) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_we) mem[b_addr] <= b_din;
        a_q <= mem[a_addr];
        b_q <= mem[b_addr];
    end
endmodule

// File: rtl/zpu_sd_bridge.sv
// Bridges ZPU firmware registers to the hps_io virtual-disk handshake.
// Define ZPU_SD_WRITE_EN to let block_wr issue sd_wr requests (otherwise images are read-only).
module zpu_sd_bridge
    import zpu_sd_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned BUF_AW    = 9
) (
    input  logic                 clk_sys,
    input  logic                 areset,
    input  logic [CTRL_W-1:0]    zpu_ctrl,
    input  logic [31:0]          zpu_wdata,
    input  logic                 zpu_io_wr,
    input  logic                 zpu_data_wr,
    input  logic                 zpu_data_rd,
    output logic [STAT_W-1:0]    zpu_status,
    output logic [31:0]          zpu_rdata,
    zpu_sd_bridge_if.master      sd,
    input  logic [NUM_SLOTS-1:0] img_mounted,
    input  logic                 img_readonly,
    input  logic [63:0]          img_size,
    input  logic [1:0]           img_type
);
    logic [CTRL_W-1:0]    ctrl_q;
    logic                 blk_rd_q2, blk_wr_q2, ack_q;
    logic                 rd_rise, wr_rise;
    logic [2:0]           drv;
    logic [SLOT_W-1:0]    slot;
    logic                 slot_ok;

    state_t               state_q, state_d;
    logic [NUM_SLOTS-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic                 io_done_q, io_done_d;

    logic                 dw_q1, dw_q2, dw_rise, dr_q, dr_fall;
    logic                 wr_stb, inc_q;
    logic [7:0]           wr_byte, buf_q;
    logic [BUF_AW-1:0]    ptr;
    logic [31:0]          lba_q, filesize_q;

    logic [NUM_SLOTS-1:0] mnt_q1;
    logic                 mnt_any_q2, mnt_rise;
    logic [SLOT_W-1:0]    mnt_hi;
    logic [FILENO_W-1:0]  fileno_q;
    logic [FILETYPE_W-1:0] filetype_q;
    logic                 mounted_q, readonly_q;
    logic                 unused_bits;

    // Control sampling and edge detection
    always_ff @(posedge clk_sys) begin
        if (areset) begin
            ctrl_q    <= '0;
            blk_rd_q2 <= 1'b0;
            blk_wr_q2 <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ctrl_q    <= zpu_ctrl;
            blk_rd_q2 <= ctrl_q[CTRL_BLOCK_RD];
            blk_wr_q2 <= ctrl_q[CTRL_BLOCK_WR];
            ack_q     <= sd.sd_ack;
        end
    end

    assign rd_rise = ctrl_q[CTRL_BLOCK_RD] & ~blk_rd_q2;
    assign wr_rise = ctrl_q[CTRL_BLOCK_WR] & ~blk_wr_q2;
    assign drv     = ctrl_q[CTRL_DRV_HI:CTRL_DRV_LO];
    assign slot    = {drv[2], drv[0]};
    assign slot_ok = (slot != SLOT_UNMAPPED) && (32'(slot) < NUM_SLOTS);

    always_ff @(posedge clk_sys) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            sd_rd_q   <= '0;
            sd_wr_q   <= '0;
            io_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            io_done_q <= io_done_d;
        end
    end

    // Block request FSM; block edges outside IDLE are dropped, read wins over write
    always_comb begin
        state_d   = state_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        io_done_d = io_done_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_rise) begin
                    if (slot_ok) begin
                        sd_rd_d[slot] = 1'b1;
                        io_done_d     = 1'b0;
                        state_d       = ST_REQ;
                    end else begin
                        io_done_d = 1'b1;
                    end
                end else if (wr_rise) begin
`ifdef ZPU_SD_WRITE_EN
                    if (slot_ok) begin
                        sd_wr_d[slot] = 1'b1;
                        io_done_d     = 1'b0;
                        state_d       = ST_REQ;
                    end else begin
                        io_done_d = 1'b1;
                    end
`else
                    io_done_d = 1'b1;
`endif
                end
            end
            ST_REQ: begin
                if (sd.sd_ack) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (ack_q && !sd.sd_ack) begin
                    io_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dw_rise = dw_q1 & ~dw_q2;
    assign dr_fall = dr_q & ~zpu_data_rd;

    // Firmware data port: LBA load or byte write, then buffer pointer advance
    always_ff @(posedge clk_sys) begin
        if (areset) begin
            dw_q1   <= 1'b0;
            dw_q2   <= 1'b0;
            dr_q    <= 1'b0;
            wr_stb  <= 1'b0;
            inc_q   <= 1'b0;
            wr_byte <= '0;
            lba_q   <= '0;
            ptr     <= '0;
        end else begin
            dw_q1  <= zpu_data_wr;
            dw_q2  <= dw_q1;
            dr_q   <= zpu_data_rd;
            wr_stb <= dw_rise & ~ctrl_q[CTRL_LBA_SEL];
            inc_q  <= wr_stb;
            if (dw_rise) begin
                if (ctrl_q[CTRL_LBA_SEL]) lba_q   <= zpu_wdata;
                else                      wr_byte <= zpu_wdata[7:0];
            end
            if (zpu_io_wr)              ptr <= '0;
            else if (inc_q || dr_fall)  ptr <= ptr + BUF_AW'(1);
        end
    end

    assign mnt_rise = (|mnt_q1) & ~mnt_any_q2;

    always_comb begin
        mnt_hi = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (mnt_q1[i]) mnt_hi = SLOT_W'(i);
        end
    end

    // Mount event latch; mounted toggles so firmware can spot each new image
    always_ff @(posedge clk_sys) begin
        if (areset) begin
            mnt_q1     <= '0;
            mnt_any_q2 <= 1'b0;
            fileno_q   <= '0;
            filetype_q <= '0;
            filesize_q <= '0;
            mounted_q  <= 1'b0;
            readonly_q <= 1'b0;
        end else begin
            mnt_q1     <= img_mounted;
            mnt_any_q2 <= |mnt_q1;
            if (mnt_rise) begin
                fileno_q   <= slot_to_fileno(mnt_hi);
                filetype_q <= img_type;
                filesize_q <= img_size[31:0];
                mounted_q  <= ~mounted_q;
`ifdef ZPU_SD_WRITE_EN
                readonly_q <= img_readonly | (mnt_hi == 2'd2);
`else
                readonly_q <= 1'b1;
`endif
            end
        end
    end

    sd_sector_buf #(.AW(BUF_AW), .DW(8)) u_buf (
        .clk_sys (clk_sys),
        .a_addr  (sd.sd_buff_addr),
        .a_din   (sd.sd_buff_dout),
        .a_we    (sd.sd_buff_wr),
        .a_q     (sd.sd_buff_din),
        .b_addr  (ptr),
        .b_din   (wr_byte),
        .b_we    (wr_stb),
        .b_q     (buf_q)
    );

    always_comb begin
        zpu_status                                     = '0;
        zpu_status[STAT_IO_DONE]                       = io_done_q;
        zpu_status[STAT_MOUNTED]                       = mounted_q;
        zpu_status[STAT_FILENO_LO +: FILENO_W]         = fileno_q;
        zpu_status[STAT_FILETYPE_LO +: FILETYPE_W]     = filetype_q;
        zpu_status[STAT_READONLY]                      = readonly_q;
    end

    assign zpu_rdata = zpu_ctrl[CTRL_LBA_SEL] ? filesize_q : {24'h0, buf_q};
    assign sd.sd_lba = lba_q;
    assign sd.sd_rd  = sd_rd_q;
    assign sd.sd_wr  = sd_wr_q;

    assign unused_bits = ^{drv[1], img_size[63:32], img_readonly};
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed, table-driven bench for zpu_sd_bridge (block FSM, data port, mount latch).
module tb_zpu_sd_bridge;
    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned BUF_AW    = 9;

    logic        clk_sys = 1'b0;
    logic        areset;
    logic [5:0]  zpu_ctrl;
    logic [31:0] zpu_wdata;
    logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
    logic [7:0]  zpu_status;
    logic [31:0] zpu_rdata;
    logic [2:0]  img_mounted;
    logic        img_readonly;
    logic [63:0] img_size;
    logic [1:0]  img_type;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] drv;
        logic [2:0] exp_rd;
    } blk_vec_t;

    typedef struct {
        logic [2:0]  mnt;
        logic        ro;
        logic [1:0]  typ;
        logic [63:0] size;
        logic [7:0]  exp_st;
        logic [31:0] exp_fs;
    } mnt_vec_t;

    zpu_sd_bridge_if #(.NUM_SLOTS(NUM_SLOTS), .BUF_AW(BUF_AW)) sd_if ();

    zpu_sd_bridge #(.NUM_SLOTS(NUM_SLOTS), .BUF_AW(BUF_AW)) dut (
        .clk_sys      (clk_sys),
        .areset       (areset),
        .zpu_ctrl     (zpu_ctrl),
        .zpu_wdata    (zpu_wdata),
        .zpu_io_wr    (zpu_io_wr),
        .zpu_data_wr  (zpu_data_wr),
        .zpu_data_rd  (zpu_data_rd),
        .zpu_status   (zpu_status),
        .zpu_rdata    (zpu_rdata),
        .sd           (sd_if),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .img_type     (img_type)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_word(input logic [2:0] drv, input logic wr,
                                             input logic rd, input logic lba);
        return {drv, wr, rd, lba};
    endfunction

    task automatic data_write(input logic [31:0] w);
        zpu_wdata   = w;
        zpu_data_wr = 1'b1;
        tick(2);
        zpu_data_wr = 1'b0;
        tick(4);
    endtask

    task automatic data_read_pulse();
        zpu_data_rd = 1'b1;
        tick(1);
        zpu_data_rd = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        blk_vec_t   bv [8];
        mnt_vec_t   mv [3];
        logic [7:0] prev_st;

        bv[0] = '{drv: 3'd5, exp_rd: 3'b000};
        bv[1] = '{drv: 3'd1, exp_rd: 3'b010};
        bv[2] = '{drv: 3'd0, exp_rd: 3'b001};
        bv[3] = '{drv: 3'd2, exp_rd: 3'b001};
        bv[4] = '{drv: 3'd3, exp_rd: 3'b010};
        bv[5] = '{drv: 3'd4, exp_rd: 3'b100};
        bv[6] = '{drv: 3'd6, exp_rd: 3'b100};
        bv[7] = '{drv: 3'd7, exp_rd: 3'b000};

        mv[0] = '{mnt: 3'b100, ro: 1'b0, typ: 2'd2, size: 64'h0000_0002_0000_4000,
                  exp_st: 8'hD2, exp_fs: 32'h0000_4000};
        mv[1] = '{mnt: 3'b011, ro: 1'b1, typ: 2'd1, size: 64'h0000_0000_0001_2345,
                  exp_st: 8'hA4, exp_fs: 32'h0001_2345};
`ifdef ZPU_SD_WRITE_EN
        mv[2] = '{mnt: 3'b001, ro: 1'b0, typ: 2'd3, size: 64'hFFFF_FFFF_8000_0000,
                  exp_st: 8'h62, exp_fs: 32'h8000_0000};
`else
        mv[2] = '{mnt: 3'b001, ro: 1'b0, typ: 2'd3, size: 64'hFFFF_FFFF_8000_0000,
                  exp_st: 8'hE2, exp_fs: 32'h8000_0000};
`endif

        areset       = 1'b1;
        zpu_ctrl     = '0;
        zpu_wdata    = '0;
        zpu_io_wr    = 1'b0;
        zpu_data_wr  = 1'b0;
        zpu_data_rd  = 1'b0;
        img_mounted  = '0;
        img_readonly = 1'b0;
        img_size     = '0;
        img_type     = '0;
        sd_if.sd_ack       = 1'b0;
        sd_if.sd_buff_addr = '0;
        sd_if.sd_buff_dout = '0;
        sd_if.sd_buff_wr   = 1'b0;
        tick(3);
        areset = 1'b0;
        tick(1);

        // Reset state
        check("rst_status", zpu_status, 8'h00);
        check("rst_sd_rd", sd_if.sd_rd, 3'b000);
        check("rst_sd_wr", sd_if.sd_wr, 3'b000);
        check("rst_sd_lba", sd_if.sd_lba, 32'h0);
        zpu_ctrl = ctrl_word(3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst_filesize", zpu_rdata, 32'h0);
        zpu_ctrl = '0;
        tick(1);

        // Mount events
        prev_st = 8'h00;
        for (int i = 0; i < 3; i++) begin
            img_mounted  = mv[i].mnt;
            img_readonly = mv[i].ro;
            img_type     = mv[i].typ;
            img_size     = mv[i].size;
            tick(1);
            check("mnt_early", zpu_status & 8'hFE, prev_st);
            tick(1);
            check("mnt_status", zpu_status & 8'hFE, mv[i].exp_st);
            zpu_ctrl = ctrl_word(3'd0, 1'b0, 1'b0, 1'b1);
            #1;
            check("mnt_filesize", zpu_rdata, mv[i].exp_fs);
            zpu_ctrl    = '0;
            img_mounted = '0;
            tick(3);
            prev_st = mv[i].exp_st;
        end

        // Block read slot mapping
        for (int i = 0; i < 8; i++) begin
            zpu_ctrl = ctrl_word(bv[i].drv, 1'b0, 1'b1, 1'b0);
            tick(1);
            check("blk_rd_early", sd_if.sd_rd, 3'b000);
            tick(1);
            check("blk_rd_req", sd_if.sd_rd, bv[i].exp_rd);
            check("blk_done_req", zpu_status[0], (bv[i].exp_rd == 3'b000));
            zpu_ctrl = ctrl_word(bv[i].drv, 1'b0, 1'b0, 1'b0);
            if (bv[i].exp_rd != 3'b000) begin
                sd_if.sd_ack = 1'b1;
                tick(1);
                check("blk_ack_clr", sd_if.sd_rd, 3'b000);
                check("blk_ack_busy", zpu_status[0], 1'b0);
                sd_if.sd_ack = 1'b0;
                tick(1);
                check("blk_ack_done", zpu_status[0], 1'b1);
            end
            tick(2);
        end

        // Long transfer with a block edge arriving mid-transfer
        zpu_ctrl = ctrl_word(3'd1, 1'b0, 1'b1, 1'b0);
        tick(2);
        check("long_req", sd_if.sd_rd, 3'b010);
        check("long_busy0", zpu_status[0], 1'b0);
        sd_if.sd_ack = 1'b1;
        tick(1);
        check("long_clr", sd_if.sd_rd, 3'b000);
        zpu_ctrl = '0;
        tick(10);
        zpu_ctrl = ctrl_word(3'd0, 1'b0, 1'b1, 1'b0);
        tick(3);
        zpu_ctrl = '0;
        check("long_ignored", sd_if.sd_rd, 3'b000);
        tick(585);
        check("long_busy", zpu_status[0], 1'b0);
        sd_if.sd_ack = 1'b0;
        tick(1);
        check("long_done", zpu_status[0], 1'b1);
        tick(2);
        check("long_no_replay", sd_if.sd_rd, 3'b000);

        // Simultaneous rd and wr: read wins
        zpu_ctrl = ctrl_word(3'd1, 1'b1, 1'b1, 1'b0);
        tick(2);
        check("both_rd", sd_if.sd_rd, 3'b010);
        check("both_wr", sd_if.sd_wr, 3'b000);
        zpu_ctrl = '0;
        sd_if.sd_ack = 1'b1;
        tick(1);
        sd_if.sd_ack = 1'b0;
        tick(1);
        check("both_done", zpu_status[0], 1'b1);
        tick(2);

        // Firmware data writes: LBA then three buffer bytes
        zpu_ctrl = ctrl_word(3'd0, 1'b0, 1'b0, 1'b1);
        tick(1);
        data_write(32'h0000_1234);
        check("lba_load", sd_if.sd_lba, 32'h0000_1234);
        zpu_ctrl  = '0;
        zpu_io_wr = 1'b1;
        tick(1);
        zpu_io_wr = 1'b0;
        tick(1);
        data_write(32'hFFFF_FFAA);
        data_write(32'h0000_00BB);
        data_write(32'h1234_56CC);
        check("lba_kept", sd_if.sd_lba, 32'h0000_1234);
        for (int a = 0; a < 3; a++) begin
            sd_if.sd_buff_addr = 9'(a);
            tick(1);
            check("hps_readback", sd_if.sd_buff_din, 8'hAA + 8'(17 * a));
        end

        // hps writes, ZPU reads with pointer increment and wrap
        sd_if.sd_buff_addr = 9'd0;
        sd_if.sd_buff_dout = 8'h5A;
        sd_if.sd_buff_wr   = 1'b1;
        tick(1);
        sd_if.sd_buff_addr = 9'd1;
        sd_if.sd_buff_dout = 8'h11;
        tick(1);
        sd_if.sd_buff_wr   = 1'b0;
        zpu_io_wr = 1'b1;
        tick(1);
        zpu_io_wr = 1'b0;
        tick(1);
        check("zpu_rd_ptr0", zpu_rdata, 32'h0000_005A);
        data_read_pulse();
        tick(1);
        check("zpu_rd_ptr1", zpu_rdata, 32'h0000_0011);
        for (int r = 0; r < 511; r++) data_read_pulse();
        tick(1);
        check("zpu_rd_wrap", zpu_rdata, 32'h0000_005A);
        data_read_pulse();
        zpu_io_wr   = 1'b1;
        zpu_data_rd = 1'b1;
        tick(1);
        zpu_data_rd = 1'b0;
        tick(1);
        zpu_io_wr = 1'b0;
        tick(1);
        check("io_wr_priority", zpu_rdata, 32'h0000_005A);
        zpu_ctrl = ctrl_word(3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rdata_filesize", zpu_rdata, 32'h8000_0000);
        zpu_ctrl = '0;
        tick(1);

        // Reset while a request is pending
        zpu_ctrl = ctrl_word(3'd0, 1'b0, 1'b1, 1'b0);
        tick(2);
        check("rstreq_pending", sd_if.sd_rd, 3'b001);
        zpu_ctrl = '0;
        areset   = 1'b1;
        tick(1);
        check("rstreq_sd_rd", sd_if.sd_rd, 3'b000);
        check("rstreq_status", zpu_status, 8'h00);
        check("rstreq_lba", sd_if.sd_lba, 32'h0);
        areset = 1'b0;
        tick(2);

        // Block write after reset
        zpu_ctrl = ctrl_word(3'd0, 1'b1, 1'b0, 1'b0);
        tick(2);
        zpu_ctrl = '0;
`ifdef ZPU_SD_WRITE_EN
        check("blk_wr_req", sd_if.sd_wr, 3'b001);
        check("blk_wr_busy", zpu_status[0], 1'b0);
        sd_if.sd_ack = 1'b1;
        tick(1);
        check("blk_wr_clr", sd_if.sd_wr, 3'b000);
        sd_if.sd_ack = 1'b0;
        tick(1);
        check("blk_wr_done", zpu_status[0], 1'b1);
`else
        check("blk_wr_none", sd_if.sd_wr, 3'b000);
        check("blk_wr_done", zpu_status[0], 1'b1);
        tick(2);
        check("blk_wr_still_none", sd_if.sd_wr, 3'b000);
`endif
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
